// File: rtl/cacheline_mem_ctrl.sv
// ---------------------------------------------------------------------------
// cacheline_mem_ctrl
//
// Cache-side memory controller sitting between the cache miss path and a
// 64-bit burst memory. One 256-bit line request becomes either:
//   - a write burst of four 64-bit beats (beat k = dfp_wdata[64k+63:64k]), or
//   - a single read request followed by a wait for the assembled 256-bit line
//     from the downstream line deserializer.
// Each completed request returns a one-cycle dfp_resp pulse.
//
// All bmem_* outputs and dfp_resp are decoded from registered state only.
//
// Optional feature macro: CLMC_TIMEOUT_EN
//   When defined, a read that sees no matching line for TIMEOUT_CYC cycles
//   in RD_WAIT goes back to RD_REQ and reissues the same address.
//
// Parameters:
//   TIMEOUT_CYC  read-wait cycles before reissue (1..256, timeout build only)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   dfp_addr    line request address ([4:0] ignored)
//   dfp_read    line read request
//   dfp_write   line write request (wins over dfp_read)
//   dfp_wdata   256-bit write line
//   dfp_rdata   256-bit read line, valid while dfp_resp=1, held afterwards
//   dfp_resp    one-cycle completion pulse
//   bmem_addr   line-aligned burst address
//   bmem_read   read request to memory
//   bmem_write  write beat valid
//   bmem_wdata  write beat data
//   bmem_ready  memory accepts the current request/beat
//   line_data   assembled read line from the deserializer
//   line_addr   address tagged with line_data
//   line_valid  one-cycle strobe for line_data/line_addr
// ---------------------------------------------------------------------------
module cacheline_mem_ctrl #(
  parameter int TIMEOUT_CYC = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic [255:0] dfp_rdata,
  output logic         dfp_resp,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [255:0] line_data,
  input  logic [31:0]  line_addr,
  input  logic         line_valid
);

  // The read-wait counter is 8 bits wide, so the timeout must fit in it.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..256");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_BURST,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [26:0]    line_q, line_d;     // latched address bits [31:5]
  logic [255:0]   wdata_q, wdata_d;
  logic [255:0]   rdata_q, rdata_d;
  logic [1:0]     cnt_q, cnt_d;

  logic           line_match;
  logic           timeout_hit;

  // Only the line part of the addresses matters; the offset bits are dropped.
  logic           unused_offset_bits;
  assign unused_offset_bits = ^{dfp_addr[4:0], line_addr[4:0]};

  assign line_match = line_valid && (line_addr[31:5] == line_q);

`ifdef CLMC_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] timer_q, timer_d;

  // Held at zero outside RD_WAIT, so every entry into RD_WAIT starts at 0.
  always_comb begin
    timer_d = '0;
    if (state_q == S_RD_WAIT) timer_d = timer_q + 8'd1;
  end

  // Expires after TIMEOUT_CYC cycles spent in RD_WAIT.
  assign timeout_hit = (state_q == S_RD_WAIT) && (timer_q == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timer_q <= '0;
    else      timer_q <= timer_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    line_d  = line_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (dfp_write) begin
          line_d  = dfp_addr[31:5];
          wdata_d = dfp_wdata;
          cnt_d   = 2'd0;
          state_d = S_WR_BURST;
        end else if (dfp_read) begin
          line_d  = dfp_addr[31:5];
          state_d = S_RD_REQ;
        end
      end

      S_RD_REQ: begin
        if (bmem_ready) state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        // A matching line wins over a timeout expiring in the same cycle.
        if (line_match) begin
          rdata_d = line_data;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_RD_REQ;
        end
      end

      S_WR_BURST: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Requests are not sampled here, so a request still high during
        // the resp cycle is not taken a second time.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
      // NOTE: the wide data registers are reset too, because dfp_rdata and
      // bmem_wdata must read as zero straight out of reset.
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Moore outputs.
  assign bmem_addr  = {line_q, 5'b0};
  assign bmem_read  = (state_q == S_RD_REQ);
  assign bmem_write = (state_q == S_WR_BURST);
  assign bmem_wdata = (state_q == S_WR_BURST) ? wdata_q[{cnt_q, 6'b0} +: 64] : '0;
  assign dfp_resp   = (state_q == S_DONE);
  assign dfp_rdata  = rdata_q;

endmodule
